// File: rtl/wr_data_pad_conv_if.sv
// Stream bundle for wr_data_pad_conv: write-data input, request-length input and padded output.
// The design takes the slave view; whoever drives the streams takes the master view.
interface wr_data_pad_conv_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) ();
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [LEN_W-1:0]  len;
  logic              len_valid;
  logic              len_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_valid, len, len_valid, m_ready,
    output s_ready, len_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, len, len_valid, m_ready,
    input  s_ready, len_ready, m_data, m_valid
  );
endinterface

// File: rtl/wr_data_pad_conv.sv
// Pads each write request to a multiple of 2^BLK_LOG2 words using pad_word as filler.
// Optional request/pad statistics counters are enabled with WR_DATA_PAD_STATS_EN.
module wr_data_pad_conv #(
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 16,
  parameter int BLK_LOG2 = 7,
  parameter int LQ_LOG2  = 4
) (
  input  logic              clk,
  input  logic              nReset,
  wr_data_pad_conv_if.slave bus,
  input  logic [DATA_W-1:0] pad_word,
  output logic              req_done,
`ifdef WR_DATA_PAD_STATS_EN
  output logic [31:0]       req_cnt,
  output logic [31:0]       pad_cnt,
`endif
  output logic [1:0]        state_o
);
  localparam int LQ_D = 1 << LQ_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DATA = 2'd2, PAD = 2'd3} state_t;

  state_t                state_reg;
  logic [LEN_W-1:0]      len_reg;
  logic [LEN_W-1:0]      cnt_reg;
  logic [BLK_LOG2-1:0]   pos_reg;
  logic                  m_valid_reg;
  logic [DATA_W-1:0]     m_data_reg;

  logic [LEN_W-1:0]      lq_mem [LQ_D];
  logic [LQ_LOG2:0]      wr_ptr_reg;
  logic [LQ_LOG2:0]      rd_ptr_reg;
  logic                  lq_empty;
  logic                  lq_full;
  logic                  lq_push;
  logic                  lq_pop;
  logic [LEN_W-1:0]      lq_head;

  logic                  load_ok;
  logic                  data_beat;
  logic                  pad_load;
  logic                  last_beat;
  logic                  pos_wrap;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign lq_empty = (wr_ptr_reg == rd_ptr_reg);
  assign lq_full  = (wr_ptr_reg[LQ_LOG2] != rd_ptr_reg[LQ_LOG2]) &&
                    (wr_ptr_reg[LQ_LOG2-1:0] == rd_ptr_reg[LQ_LOG2-1:0]);
  assign lq_head  = lq_mem[rd_ptr_reg[LQ_LOG2-1:0]];
  assign lq_push  = bus.len_valid & bus.len_ready;
  assign lq_pop   = (state_reg == LOAD);

  assign bus.len_ready = nReset & ~lq_full;

  assign load_ok   = ~m_valid_reg | bus.m_ready;
  assign data_beat = (state_reg == DATA) & bus.s_valid & load_ok;
  assign pad_load  = (state_reg == PAD) & load_ok;
  assign last_beat = (cnt_reg == len_reg - LEN_W'(1));
  assign pos_wrap  = &pos_reg;

  assign bus.s_ready = (state_reg == DATA) & load_ok;
  assign bus.m_valid = m_valid_reg;
  assign bus.m_data  = m_data_reg;
  assign state_o     = state_reg;

  // Completion coincides with the final load; a zero-length request completes in LOAD.
  assign req_done = ((state_reg == LOAD) && (lq_head == '0)) |
                    (data_beat & last_beat & pos_wrap) |
                    (pad_load & pos_wrap);

  always_ff @(posedge clk) begin
    if (lq_push)
      lq_mem[wr_ptr_reg[LQ_LOG2-1:0]] <= bus.len;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (lq_push) wr_ptr_reg <= wr_ptr_reg + (LQ_LOG2+1)'(1);
      if (lq_pop)  rd_ptr_reg <= rd_ptr_reg + (LQ_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      cnt_reg   <= '0;
      pos_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: if (!lq_empty) state_reg <= LOAD;
        LOAD: begin
          len_reg   <= lq_head;
          cnt_reg   <= '0;
          pos_reg   <= '0;
          state_reg <= (lq_head != '0) ? DATA : IDLE;
        end
        DATA: if (data_beat) begin
          cnt_reg <= cnt_reg + LEN_W'(1);
          pos_reg <= pos_reg + BLK_LOG2'(1);
          if (last_beat) state_reg <= pos_wrap ? IDLE : PAD;
        end
        PAD: if (pad_load) begin
          pos_reg <= pos_reg + BLK_LOG2'(1);
          if (pos_wrap) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
    end else if (data_beat) begin
      m_valid_reg <= 1'b1;
      m_data_reg  <= bus.s_data;
    end else if (pad_load) begin
      m_valid_reg <= 1'b1;
      m_data_reg  <= pad_word;
    end else if (bus.m_ready) begin
      m_valid_reg <= 1'b0;
    end
  end

`ifdef WR_DATA_PAD_STATS_EN
  logic [31:0] req_cnt_reg;
  logic [31:0] pad_cnt_reg;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      req_cnt_reg <= '0;
      pad_cnt_reg <= '0;
    end else begin
      if (req_done) req_cnt_reg <= req_cnt_reg + 32'd1;
      if (pad_load) pad_cnt_reg <= pad_cnt_reg + 32'd1;
    end
  end

  assign req_cnt = req_cnt_reg;
  assign pad_cnt = pad_cnt_reg;
`endif
endmodule

// File: tb/tb_wr_data_pad_conv.sv
// Directed bench for wr_data_pad_conv: hand-built expected streams, immediate-assertion checks.
module tb_wr_data_pad_conv;
  logic        clk;
  logic        nReset;
  logic [31:0] pad_word;
  logic        req_done;
  logic [1:0]  state_o;
`ifdef WR_DATA_PAD_STATS_EN
  logic [31:0] req_cnt;
  logic [31:0] pad_cnt;
`endif

  wr_data_pad_conv_if #(.DATA_W(32), .LEN_W(16)) bus ();

  wr_data_pad_conv #(.DATA_W(32), .LEN_W(16), .BLK_LOG2(7), .LQ_LOG2(4)) dut (
    .clk      (clk),
    .nReset   (nReset),
    .bus      (bus),
    .pad_word (pad_word),
    .req_done (req_done),
`ifdef WR_DATA_PAD_STATS_EN
    .req_cnt  (req_cnt),
    .pad_cnt  (pad_cnt),
`endif
    .state_o  (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          to_cnt   = 0;
  bit          abort    = 0;
  logic [31:0] got_q [$];
  logic [31:0] exp_q [$];
  int          done_at [$];

  // Output words are captured at the negative edge, ahead of the accepting rising edge.
  always @(negedge clk) begin
    if (nReset) begin
      if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
      if (req_done) done_at.push_back(got_q.size());
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int done_pos(input int i);
    if (i < done_at.size()) return done_at[i];
    return -1;
  endfunction

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    done_at.delete();
  endtask

  task automatic build_exp(input int n, input logic [31:0] base, input logic [31:0] pad);
    int total;
    total = ((n + 127) / 128) * 128;
    for (int i = 0; i < total; i++)
      exp_q.push_back((i < n) ? base + 32'(i) : pad);
  endtask

  task automatic push_len(input logic [15:0] l);
    int  g;
    bit  acc;
    g = 0;
    acc = 0;
    bus.len       = l;
    bus.len_valid = 1'b1;
    while (!acc && g < 2000) begin
      @(negedge clk);
      acc = bus.len_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) to_cnt++;
    bus.len_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    for (int i = 0; i < n && !abort; i++) begin
      int g;
      bit acc;
      g = 0;
      acc = 0;
      bus.s_data  = base + 32'(i);
      bus.s_valid = 1'b1;
      while (!acc && !abort && g < 2000) begin
        @(negedge clk);
        acc = bus.s_ready;
        @(posedge clk);
        #1;
        g++;
      end
      if (!acc && !abort) begin
        to_cnt++;
        break;
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_out(input int nw, input int nd);
    int g;
    g = 0;
    while ((got_q.size() < nw || done_at.size() < nd) && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 5000) to_cnt++;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic compare(input string tag, input int exp_done);
    int bad;
    int first;
    bad = 0;
    first = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    $display("req %s: words=%0d expected_words=%0d done_pulses=%0d first_bad=%0d",
             tag, got_q.size(), exp_q.size(), done_at.size(), first);
    check({tag, "_words"}, 64'(got_q.size()), 64'(exp_q.size()));
    check({tag, "_data"}, 64'(bad), 64'd0);
    check({tag, "_done"}, 64'(done_at.size()), 64'(exp_done));
  endtask

  initial begin
    int          stall_bad;
    int          g;
    logic [31:0] held_d;

    nReset        = 1'b0;
    bus.s_data    = '0;
    bus.s_valid   = 1'b0;
    bus.len       = '0;
    bus.len_valid = 1'b0;
    bus.m_ready   = 1'b1;
    pad_word      = 32'hDEADBEEF;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_req_done", 64'(req_done), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_len_ready", 64'(bus.len_ready), 64'd0);
    nReset = 1'b1;
    #1;
    check("rel_len_ready", 64'(bus.len_ready), 64'd1);
    check("rel_state", 64'(state_o), 64'd0);
    @(posedge clk);
    #1;

    // Exact block: no padding
    clear_all();
    build_exp(128, 32'h0000_1000, 32'hDEADBEEF);
    push_len(16'd128);
    feed(128, 32'h0000_1000);
    wait_out(128, 1);
    compare("len128", 1);
    check("len128_done_at", 64'(done_pos(0)), 64'd127);

    // Short request padded with 0xDEADBEEF
    clear_all();
    build_exp(5, 32'd1, 32'hDEADBEEF);
    push_len(16'd5);
    feed(5, 32'd1);
    wait_out(128, 1);
    compare("len5", 1);
    check("len5_done_at", 64'(done_pos(0)), 64'd127);

    // Zero-length request followed by len=3
    clear_all();
    pad_word = 32'h5A5A_0003;
    build_exp(3, 32'h0000_0300, 32'h5A5A_0003);
    push_len(16'd0);
    push_len(16'd3);
    feed(3, 32'h0000_0300);
    wait_out(128, 2);
    compare("len0_3", 2);
    check("len0_done_at", 64'(done_pos(0)), 64'd0);
    check("len3_done_at", 64'(done_pos(1)), 64'd127);

    // Back-pressure stall for 10 cycles at word 64
    clear_all();
    pad_word = 32'hA5A5_0130;
    build_exp(130, 32'h0000_4000, 32'hA5A5_0130);
    stall_bad = 0;
    push_len(16'd130);
    fork
      feed(130, 32'h0000_4000);
      begin
        g = 0;
        while (got_q.size() < 64 && g < 2000) begin
          @(posedge clk);
          #1;
          g++;
        end
        bus.m_ready = 1'b0;
        held_d = bus.m_data;
        repeat (10) begin
          @(negedge clk);
          if (bus.m_data !== held_d || bus.m_valid !== 1'b1 || bus.s_ready !== 1'b0)
            stall_bad++;
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
      end
    join
    wait_out(256, 1);
    compare("len130_stall", 1);
    check("stall_hold", 64'(stall_bad), 64'd0);

    // Fill the length queue while the FSM waits for data
    clear_all();
    pad_word = 32'hDEADBEEF;
    build_exp(1, 32'h0000_0077, 32'hDEADBEEF);
    push_len(16'd1);
    g = 0;
    while (state_o !== 2'd2 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("lq_fsm_in_data", 64'(state_o), 64'd2);
    for (int i = 0; i < 16; i++) begin
      push_len(16'd0);
      if (i == 14) check("lq_ready_after15", 64'(bus.len_ready), 64'd1);
    end
    check("lq_ready_after16", 64'(bus.len_ready), 64'd0);
    feed(1, 32'h0000_0077);
    g = 0;
    while (bus.len_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("lq_ready_after_pop", 64'(bus.len_ready), 64'd1);
    wait_out(128, 17);
    compare("lq_full", 17);

    // Reset at word 40 of len=100, then len=2
    clear_all();
    push_len(16'd100);
    fork
      feed(100, 32'h0000_6000);
      begin
        g = 0;
        while (got_q.size() < 40 && g < 2000) begin
          @(posedge clk);
          #1;
          g++;
        end
        abort = 1;
        nReset = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        check("midrst_m_valid", 64'(bus.m_valid), 64'd0);
        check("midrst_state", 64'(state_o), 64'd0);
        check("midrst_s_ready", 64'(bus.s_ready), 64'd0);
        check("midrst_len_ready", 64'(bus.len_ready), 64'd0);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    abort  = 0;
    clear_all();
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_residue", 64'(got_q.size() + done_at.size()), 64'd0);
    build_exp(2, 32'h0000_7000, 32'hDEADBEEF);
    push_len(16'd2);
    feed(2, 32'h0000_7000);
    wait_out(128, 1);
    compare("after_rst_len2", 1);

    check("timeouts", 64'(to_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wr_data_pad_conv.md
WR_DATA_PAD_CONV -- requirements
Module: wr_data_pad_conv

Interface
REQ-001 Parameter DATA_W, 32, width of data words on input and output streams.
REQ-002 Parameter LEN_W, 16, width of request length field in words.
REQ-003 Parameter BLK_LOG2, 7, log2 of block size in words; every request output is padded to a multiple of 2^BLK_LOG2 words.
REQ-004 Parameter LQ_LOG2, 4, log2 of length-queue depth.
REQ-005 Ports: clk in 1, the only clock; all logic is on its rising edge.
REQ-006 Ports: nReset in 1, asynchronous active-low reset.
REQ-007 Ports: s_data in DATA_W, s_valid in 1, s_ready out 1, the write-data input stream.
REQ-008 Ports: len in LEN_W, len_valid in 1, len_ready out 1, the request length in words.
REQ-009 Ports: m_data out DATA_W, m_valid out 1, m_ready in 1, the padded output stream.
REQ-010 Ports: pad_word in DATA_W, the fill value for pad words, sampled when each pad word is loaded.
REQ-011 Ports: req_done out 1, a one-cycle pulse when a request finishes.
REQ-012 Ports: state_o out 2, the current FSM state.

Function
REQ-013 Length queue:
- FIFO of 2^LQ_LOG2 entries; len_ready=~full.
- Push on len_valid&len_ready.
- len_ready ignores a pop in the same cycle.
- Push and pop in the same cycle are both honoured.
REQ-014 FSM states: IDLE=0, LOAD=1, DATA=2, PAD=3.
REQ-015 IDLE goes to LOAD when the queue is non-empty.
REQ-016 LOAD:
- Pops one entry into len_r.
- Clears word counter cnt (LEN_W) and block position pos (BLK_LOG2 bits).
- Goes to DATA if the popped length is non-zero.
- If the popped length is 0, pulses req_done and goes to IDLE with no output.
REQ-017 Output register:
- Single-entry register; load_ok = ~m_valid | m_ready.
- m_valid is set on load and cleared when m_ready is high and there is no load.
- m_data holds while m_valid&~m_ready.
REQ-018 DATA state:
- s_ready = load_ok, and s_ready is 0 in all other states.
- Each s_valid&s_ready beat loads s_data, increments cnt, and increments pos modulo 2^BLK_LOG2.
REQ-019 DATA exit, on the beat where cnt==len_r-1:
- If pos+1 wraps to 0, go to IDLE and pulse req_done.
- Otherwise go to PAD.
REQ-020 PAD state:
- Each cycle with load_ok loads pad_word and increments pos.
- On the load where pos+1 wraps to 0, go to IDLE and pulse req_done.
REQ-021 Latency: a word loaded in cycle N is presented with m_valid=1 in cycle N+1, with no bubbles under continuous valid/ready.
REQ-022 Total output per request is ceil(len/2^BLK_LOG2)*2^BLK_LOG2 words, in input order.
REQ-023 Lengths up to 2^LEN_W-1 are legal, and the counters do not overflow.
REQ-024 req_done asserts in the same cycle as the final load.

Reset
REQ-025 Asserting nReset immediately clears the FSM to IDLE, empties the queue, and clears cnt, pos and len_r.
REQ-026 Outputs during reset:
- m_valid=0, m_data=0, s_ready=0, req_done=0, state_o=0.
- len_ready=0 while nReset is low, and 1 after it is released.
REQ-027 Reset mid-request discards the partial request, and no pad completion follows.

Configuration
REQ-028 Macro WR_DATA_PAD_STATS_EN.
- Defined: adds output ports req_cnt (32) and pad_cnt (32), counting completed requests and emitted pad words; both wrap at 2^32 and are cleared by reset.
- Undefined: the ports and their logic are absent, and all other behaviour is unchanged.

Verification
REQ-029 len=128, 128 input beats, m_ready=1 -> 128 data words out, no pad, 1 req_done pulse.
REQ-030 len=5, data 1..5, pad_word=0xDEADBEEF -> 1..5 followed by 123 words of 0xDEADBEEF, 1 req_done pulse.
REQ-031 len=0 then len=3 -> no output for the first, req_done pulse, then 3 data words and 125 pad words.
REQ-032 len=130, m_ready low for 10 cycles at word 64 -> m_data is stable while stalled, 256 words total, no loss or duplication.
REQ-033 16 lengths pushed with the FSM stalled -> len_ready=0 after the 16th push, and it returns to 1 after the first pop.
REQ-034 nReset low at word 40 of len=100 -> m_valid=0 and state_o=0 immediately, and the next request (len=2) gives 2 data words and 126 pad words.
